dmem_hs: RTL and testbench
==========================

// Module: dmem_hs
// PURPOSE
//  Clocked, parametrised data memory for the datapath. Successor to the combinational
//  data memory. Supports byte-enable writes, a registered read with programmable latency
//  and a valid/ready request/response handshake. One request is outstanding at a time,
//  so the pipeline can stall on memory without losing accesses.
// PARAMETERS
//  DATA_W  32  word width in bits; multiple of 8, >=8
//  DEPTH   32  number of words; power of 2, >=2
//  RD_LAT  1   cycles from request accept to response valid; 1..4
//  ADDR_W  32  byte-address width; must cover DEPTH*DATA_W/8
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables; bit i selects req_wdata[8i+7:8i]
//  rsp_valid  out  1         response present (read data or write ack)
//  rsp_ready  in   1         consumer accepts the response
//  rsp_rdata  out  DATA_W    read data; 0 for write acks
//  rsp_err    out  1         access error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: req_ready=0 in the rst cycle, then 1; rsp_valid=0, rsp_rdata=0,
//    rsp_err=0; FSM=IDLE; latency counter=0. Array contents are NOT reset.
//  - Word index = req_addr[LSB +: IDX_W], where LSB=$clog2(DATA_W/8) and IDX_W=$clog2(DEPTH).
//  - FSM states:
//    IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/err.
//      Write: on the accept edge, update the enabled bytes only; be=0 writes nothing.
//      Next state: WAIT if RD_LAT>1, else RESP.
//    WAIT: req_ready=0. Counter counts RD_LAT-1 cycles, then go to RESP.
//    RESP: rsp_valid=1, req_ready=0. rsp_* held stable until rsp_valid&&rsp_ready,
//      then go to IDLE.
//  - A read is accepted on edge N. rsp_valid rises after edge N+RD_LAT-1 (RD_LAT=1: valid
//    in the cycle after accept). rsp_rdata is the array word sampled at accept.
//  - Write ack: same timing as a read; rsp_rdata=0.
//  - Back-to-back: because req_ready=0 in RESP, max throughput is one access per RD_LAT+1
//    cycles.
//  - rsp_valid never drops without rsp_ready. Inputs are ignored outside IDLE.
//  - Reset mid-operation: a pending response is discarded and the FSM returns to IDLE. A
//    write already accepted stays committed.
// CONFIGURATION
//  Macro DMEM_HS_ERR_CHECK_EN:
//   defined: rsp_err=1 when req_addr[LSB-1:0]!=0 (misaligned) or the address is beyond
//     DEPTH words. An erroring write leaves the array unchanged. An erroring read returns
//     rsp_rdata=0. Handshake timing is unchanged.
//   undefined: rsp_err tied 0. Low offset bits are ignored and upper bits are truncated,
//     so the address wraps modulo DEPTH words.
// STRUCTURE
//  - Package dmem_hs_pkg: FSM state enum (IDLE, WAIT, RESP), and functions for LSB and
//    IDX_W derivation.
//  - One sub-module, dmem_hs_array: single-port byte-enable RAM
//    (clk, we, be, idx, wdata, rdata) with registered read.
//  - The top holds the FSM, latency counter, error check and response registers.
// TESTING  (DATA_W=32, DEPTH=32, RD_LAT=1 unless noted)
//  - Write 0xDEADBEEF to addr 0x08, be=4'hF, then read 0x08 -> rsp_rdata=0xDEADBEEF,
//    rsp_err=0, rsp_valid one cycle after accept.
//  - Partial write 0x000000AA to 0x08 with be=4'b0001 -> read returns 0xDEADBEAA.
//  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0
//    throughout; release -> IDLE next cycle.
//  - RD_LAT=3: read accepted at edge N -> rsp_valid first seen after edge N+2; a second
//    req_valid during WAIT is not accepted.
//  - With DMEM_HS_ERR_CHECK_EN: write to 0x0A -> rsp_err=1, word 2 unchanged. Read 0x80
//    -> rsp_err=1, rdata=0. Without the macro: read 0x88 returns word 2.
//  - Assert rst while in RESP -> next cycle rsp_valid=0 and state IDLE; a prior write to
//    0x08 is still readable.

Source files
------------

// File: rtl/dmem_hs_pkg.sv
// dmem_hs_pkg: FSM state encoding and geometry helpers shared by the dmem_hs files.
package dmem_hs_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic int f_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int f_idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/dmem_hs_array.sv
// dmem_hs_array: single-port byte-enable RAM with a registered read port.
module dmem_hs_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W / 8; i++)
            if (we && be[i]) r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= r_mem[idx];
    end
endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: clocked data memory with valid/ready handshake and programmable read latency.
// Optional address checking is enabled by defining DMEM_HS_ERR_CHECK_EN.
module dmem_hs
    import dmem_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int LSB = f_lsb(DATA_W);
    localparam int IDX_W = f_idx_w(DEPTH);
    localparam logic [1:0] CNT_MAX = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    state_t             r_state, w_next;
    logic [1:0]         r_cnt, w_cnt_nxt;
    logic               r_we, r_err;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx, w_arr_idx;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_accept, w_err, w_unused;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[LSB +: IDX_W];
    assign w_unused  = ^req_addr;

`ifdef DMEM_HS_ERR_CHECK_EN
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << LSB) - 64'd1);
    assign w_err = (|(req_addr & OFF_MASK)) || (|(req_addr >> (LSB + IDX_W)));
`else
    assign w_err = 1'b0;
`endif

    // Hold the latched index after accept so the registered read stays stable until the handshake.
    assign w_arr_idx = (r_state == IDLE) ? w_idx : r_idx;

    dmem_hs_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .we    (w_accept && req_we && !w_err),
        .be    (req_be),
        .idx   (w_arr_idx),
        .wdata (req_wdata),
        .rdata (w_rdata)
    );

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            IDLE: if (w_accept) begin
                w_next    = (RD_LAT > 1) ? WAIT : RESP;
                w_cnt_nxt = '0;
            end
            WAIT: if (r_cnt == CNT_MAX) begin
                w_next    = RESP;
                w_cnt_nxt = '0;
            end else w_cnt_nxt = r_cnt + 2'd1;
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we  <= req_we;
                r_err <= w_err;
                r_idx <= w_idx;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_rdata : '0;
    assign rsp_err   = rsp_valid && r_err;
endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed scoreboard bench for dmem_hs at RD_LAT=1 and RD_LAT=3.
module tb_dmem_hs;
    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_be = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_hs #(.DATA_W(32), .DEPTH(32), .RD_LAT(1), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_hs #(.DATA_W(32), .DEPTH(32), .RD_LAT(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge just after the accepting rising edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] ed, input logic ee);
        int n = 0;
        q.push_back('{d: ed, e: ee});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic rsp_chk(input string tag);
        exp_t e = q.pop_front();
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, e.d);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.e});
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] ed, input logic ee, input string tag);
        issue(we, addr, wd, be, ed, ee);
        rsp_chk(tag);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // RD_LAT=3 access; optionally keeps a stray write request up during the first WAIT cycle.
    task automatic access_b(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] ed, input logic hold, input string tag);
        int n = 0;
        exp_t e;
        q.push_back('{d: ed, e: 1'b0});
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_be = 4'hF;
        while (!b_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_wait"}, {31'd0, b_req_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_v1"}, {31'd0, b_rsp_valid}, 32'd0);
        chk({tag, "_r1"}, {31'd0, b_req_ready}, 32'd0);
        b_req_valid = hold;
        b_req_we = 1'b1; b_req_wdata = 32'h2222_2222;
        @(negedge clk);
        b_req_valid = 1'b0;
        chk({tag, "_v2"}, {31'd0, b_rsp_valid}, 32'd0);
        chk({tag, "_r2"}, {31'd0, b_req_ready}, 32'd0);
        @(negedge clk);
        e = q.pop_front();
        chk({tag, "_v3"}, {31'd0, b_rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, b_rsp_rdata, e.d);
        chk({tag, "_err"}, {31'd0, b_rsp_err}, {31'd0, e.e});
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, b_rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        access(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr_full");
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd_full");
        access(1'b1, 32'h08, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, "wr_byte0");
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_byte0");
        access(1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "wr_be0");
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_be0");
        access(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "wr_w4");
        access(1'b1, 32'h10, 32'h00AB_CD00, 4'b0110, 32'h0, 1'b0, "wr_mid");
        access(1'b0, 32'h10, 32'h0, 4'h0, 32'hCAAB_CD0D, 1'b0, "rd_mid");

        rsp_ready = 1'b0;
        issue(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);
        rsp_chk("hold_first");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h1234_5678; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEAD_BEAA);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_after_hold");

`ifdef DMEM_HS_ERR_CHECK_EN
        access(1'b1, 32'h0A, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "wr_misalign");
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_unchanged");
        access(1'b0, 32'h80, 32'h0, 4'h0, 32'h0, 1'b1, "rd_range");
`else
        access(1'b0, 32'h88, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_wrap");
        access(1'b0, 32'h0B, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_lowbits");
`endif

        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hCAAB_CD0D, 1'b0);
        rsp_chk("rst_mid_pre");
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1 chk("rst_mid_idle", {31'd0, req_ready}, 32'd1);
        access(1'b0, 32'h08, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, "rd_after_rst");

        access_b(1'b1, 32'h0C, 32'h1111_1111, 32'h0, 1'b0, "b_wr");
        access_b(1'b0, 32'h0C, 32'h0, 32'h1111_1111, 1'b1, "b_rd_hold");
        access_b(1'b0, 32'h0C, 32'h0, 32'h1111_1111, 1'b0, "b_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
